// File: rtl/fifo_rx_handshake.sv
// rtl/fifo_rx_handshake.sv - input-channel receive FIFO with RTS/CTS flit handshake
module fifo_rx_handshake #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       DRTS,
  input  logic [DATA_WIDTH-1:0]      RX,
  output logic                       CTS,
  input  logic                       read_en_N,
  input  logic                       read_en_E,
  input  logic                       read_en_W,
  input  logic                       read_en_S,
  input  logic                       read_en_L,
  output logic [DATA_WIDTH-1:0]      Data_out,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Handshake state: CTS is simply the registered ACK state bit.
  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           wptr_q, wptr_d;
  logic [PW-1:0]           rptr_q, rptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [DEPTH];

  logic                    any_grant;
  logic                    write_en;
  logic                    read_en;

  // Status flags come from the occupancy counter, i.e. pre-edge state.
  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign count    = count_q;
  assign CTS      = (state_q == ST_ACK);
  assign Data_out = mem_q[rptr_q];

  // Any arbiter grant is one pop; a pop on an empty FIFO is dropped.
  assign any_grant = read_en_N | read_en_E | read_en_W | read_en_S | read_en_L;
  assign read_en   = any_grant & ~empty;
  // Capture only in WAIT so a held RTS during ACK cannot write twice.
  assign write_en  = DRTS & (state_q == ST_WAIT) & ~full;

  // Next-state logic for handshake, pointers, occupancy and storage.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    mem_d   = mem_q;

    case (state_q)
      ST_WAIT: if (write_en) state_d = ST_ACK;
      ST_ACK:  state_d = ST_WAIT;
      default: state_d = ST_WAIT;
    endcase

    if (write_en) begin
      mem_d[wptr_q] = RX;
      wptr_d        = wptr_q + 1'b1;
    end

    if (read_en) begin
      rptr_d = rptr_q + 1'b1;
    end

    if (write_en && !read_en) begin
      count_d = count_q + 1'b1;
    end else if (read_en && !write_en) begin
      count_d = count_q - 1'b1;
    end
  end

  // Control state; asynchronous reset empties the FIFO and drops CTS at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_WAIT;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Flit storage is not reset; content is meaningless while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_fifo_rx_handshake.sv
// tb/tb_fifo_rx_handshake.sv - directed self-checking bench for fifo_rx_handshake
module tb_fifo_rx_handshake;

  logic        clk;
  logic        rst;
  logic        DRTS;
  logic [31:0] RX;
  logic        CTS;
  logic        read_en_N, read_en_E, read_en_W, read_en_S, read_en_L;
  logic [31:0] Data_out;
  logic        empty, full;
  logic [2:0]  count;

  int pass_cnt = 0;
  int total    = 0;

  fifo_rx_handshake #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .DRTS(DRTS), .RX(RX), .CTS(CTS),
    .read_en_N(read_en_N), .read_en_E(read_en_E), .read_en_W(read_en_W),
    .read_en_S(read_en_S), .read_en_L(read_en_L),
    .Data_out(Data_out), .empty(empty), .full(full), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_grants();
    read_en_N = 0; read_en_E = 0; read_en_W = 0; read_en_S = 0; read_en_L = 0;
  endtask

  // Upstream sender: raise RTS, wait for CTS, drop RTS, let ACK finish.
  task automatic send_flit(input logic [31:0] d);
    bit got;
    got = 0;
    RX = d; DRTS = 1;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (CTS) got = 1;
    end
    DRTS = 0;
    total++;
    if (got !== 1'b1) $display("FAIL send_cts_timeout data=%h got=%0d exp=1", d, got);
    else pass_cnt++;
    tick();
  endtask

  task automatic pop_check(input logic [31:0] exp, input string nm);
    total++;
    if (Data_out !== exp) $display("FAIL %s got=%h exp=%h", nm, Data_out, exp);
    else pass_cnt++;
    read_en_S = 1;
    tick();
    read_en_S = 0;
  endtask

  task automatic test_reset();
    rst = 1; DRTS = 0; RX = '0; clear_grants();
    tick(); tick();
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({CTS, empty, full, count} !== {1'b0, 1'b1, 1'b0, 3'd0})
        $display("FAIL reset_idle cyc=%0d got cts=%b e=%b f=%b c=%0d exp 0/1/0/0", i, CTS, empty, full, count);
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    int pulses;
    pulses = 0;
    RX = 32'hDEADBEEF; DRTS = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (CTS) begin pulses++; DRTS = 0; end
    end
    total++;
    if (pulses !== 1) $display("FAIL single_pulses got=%0d exp=1", pulses); else pass_cnt++;
    total++;
    if ({count, empty} !== {3'd1, 1'b0}) $display("FAIL single_state got c=%0d e=%b exp 1/0", count, empty); else pass_cnt++;
    pop_check(32'hDEADBEEF, "single_data");
    total++;
    if (empty !== 1'b1) $display("FAIL single_empty_after_pop got=%b exp=1", empty); else pass_cnt++;
  endtask

  task automatic test_fill();
    logic [31:0] fl [5];
    int pulses, idx;
    bit got;
    fl[0] = 32'hA0A0A0A0; fl[1] = 32'hB1B1B1B1; fl[2] = 32'hC2C2C2C2;
    fl[3] = 32'hD3D3D3D3; fl[4] = 32'hE4E4E4E4;
    pulses = 0; idx = 0;
    RX = fl[0]; DRTS = 1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (CTS) begin
        pulses++; idx++;
        if (idx < 5) RX = fl[idx];
      end
    end
    total++;
    if (pulses !== 4) $display("FAIL fill_pulses got=%0d exp=4", pulses); else pass_cnt++;
    total++;
    if ({full, count} !== {1'b1, 3'd4}) $display("FAIL fill_full got f=%b c=%0d exp 1/4", full, count); else pass_cnt++;
    total++;
    if (Data_out !== fl[0]) $display("FAIL fill_head got=%h exp=%h", Data_out, fl[0]); else pass_cnt++;
    read_en_E = 1;
    tick();
    read_en_E = 0;
    got = 0;
    for (int i = 0; i < 2 && !got; i++) begin
      tick();
      if (CTS) got = 1;
    end
    DRTS = 0;
    total++;
    if (got !== 1'b1) $display("FAIL fill_cts_after_pop got=%0d exp=1", got); else pass_cnt++;
    tick();
    total++;
    if (count !== 3'd4) $display("FAIL fill_refill_count got=%0d exp=4", count); else pass_cnt++;
    for (int i = 1; i < 5; i++) pop_check(fl[i], "fill_order");
    total++;
    if (empty !== 1'b1) $display("FAIL fill_drained got=%b exp=1", empty); else pass_cnt++;
  endtask

  task automatic test_empty_read();
    read_en_W = 1;
    tick();
    read_en_W = 0;
    total++;
    if ({empty, count} !== {1'b1, 3'd0}) $display("FAIL empty_read_ignored got e=%b c=%0d exp 1/0", empty, count); else pass_cnt++;
    RX = 32'h0BADF00D; DRTS = 1; read_en_W = 1;
    tick();
    DRTS = 0; read_en_W = 0;
    total++;
    if ({CTS, count, Data_out} !== {1'b1, 3'd1, 32'h0BADF00D})
      $display("FAIL empty_rw got cts=%b c=%0d d=%h exp 1/1/0badf00d", CTS, count, Data_out);
    else pass_cnt++;
    tick();
    pop_check(32'h0BADF00D, "empty_rw_pop");
  endtask

  task automatic test_back_to_back();
    send_flit(32'h11110001);
    send_flit(32'h22220002);
    total++;
    if (count !== 3'd2) $display("FAIL rw_pre_count got=%0d exp=2", count); else pass_cnt++;
    RX = 32'h33330003; DRTS = 1; read_en_W = 1;
    tick();
    DRTS = 0; read_en_W = 0;
    total++;
    if ({count, Data_out} !== {3'd2, 32'h22220002})
      $display("FAIL rw_simul got c=%0d d=%h exp 2/22220002", count, Data_out);
    else pass_cnt++;
    tick();
    pop_check(32'h22220002, "rw_order");
    pop_check(32'h33330003, "rw_order");
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    int maxc;
    maxc = 0;
    for (int i = 0; i < 10; i++) begin
      v = 32'h5A000000 + 32'(i * 7 + 1);
      send_flit(v);
      if (int'(count) > maxc) maxc = int'(count);
      pop_check(v, "wrap_data");
    end
    total++;
    if (maxc !== 1) $display("FAIL wrap_maxcount got=%0d exp=1", maxc); else pass_cnt++;
  endtask

  task automatic test_multigrant_reset();
    send_flit(32'hCAFE0001);
    send_flit(32'hCAFE0002);
    send_flit(32'hCAFE0003);
    read_en_N = 1; read_en_L = 1;
    tick();
    clear_grants();
    total++;
    if ({count, Data_out} !== {3'd2, 32'hCAFE0002})
      $display("FAIL multigrant got c=%0d d=%h exp 2/cafe0002", count, Data_out);
    else pass_cnt++;
    RX = 32'hFEEDFACE; DRTS = 1;
    tick();
    total++;
    if (CTS !== 1'b1) $display("FAIL mid_hs_cts got=%b exp=1", CTS); else pass_cnt++;
    #1 rst = 1;
    #1;
    total++;
    if ({CTS, empty, count} !== {1'b0, 1'b1, 3'd0})
      $display("FAIL async_reset got cts=%b e=%b c=%0d exp 0/1/0", CTS, empty, count);
    else pass_cnt++;
    DRTS = 0;
    tick();
    rst = 0;
    tick();
    total++;
    if ({CTS, empty, full, count} !== {1'b0, 1'b1, 1'b0, 3'd0})
      $display("FAIL post_reset got cts=%b e=%b f=%b c=%0d exp 0/1/0/0", CTS, empty, full, count);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_empty_read();
    test_back_to_back();
    test_wrap();
    test_multigrant_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
